ab_display_scheduler: RTL and testbench
=======================================

Name: ab_display_scheduler

Overview:
- Shares the operand-display/compute datapath between two requesters, each supplying a 4-bit operand pair {a,b}.
- Each granted transaction shows {a,b} for SHOW_TICKS timer ticks, then a result for RES_TICKS ticks, then acknowledges the requester.
- The result is a-b when a>b, otherwise the Gray code of {a,b}.
- The dwell timer is internal, so no external counter handshake is needed.

Parameters:
- TICK_DIV, 4, clock cycles per timer tick (>=1)
- SHOW_TICKS, 6, ticks spent in SHOW phase (>=1)
- RES_TICKS, 3, ticks spent in result phase (>=1)

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high; returns block to IDLE
- req0  in  1  requester 0 request, level, held until ack0
- a0  in  4  requester 0 operand a
- b0  in  4  requester 0 operand b
- req1  in  1  requester 1 request, level, held until ack1
- a1  in  4  requester 1 operand a
- b1  in  4  requester 1 operand b
- ack0  out  1  one-cycle completion pulse to requester 0
- ack1  out  1  one-cycle completion pulse to requester 1
- busy  out  1  high while a transaction is in progress (phase != 00)
- grant_id  out  1  requester owning the current or most recent transaction
- phase  out  2  00 IDLE, 01 SHOW, 10 RESULT_SUB, 11 RESULT_GRAY
- disp_value  out  8  value driven to the display

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high on `reset`.
- All outputs are registered.
- Reset values: phase=00, busy=0, ack0=ack1=0, disp_value=8'hFF, grant_id=0. The internal last_served register resets to 1, so requester 0 wins the first contention.
- Reset mid-transaction: on the next edge the block is in IDLE with reset values, no ack is issued, and latched operands are discarded.
- IDLE:
  - disp_value=8'hFF.
  - On an edge where at least one req is high and neither ack is high this cycle, grant and go to SHOW.
  - The cycle carrying an ack is IDLE, and requests are ignored in it. The minimum gap between transactions is therefore 2 IDLE cycles.
- Arbitration:
  - Only one request high: grant it.
  - Both high: grant the requester != last_served (round robin).
  - On grant: grant_id and last_served are updated, and that requester's a,b are latched. Later operand changes are ignored until the next grant.
- Timer:
  - The prescaler counts 0..TICK_DIV-1; a tick occurs when the prescaler reaches TICK_DIV-1.
  - The tick counter counts ticks within the current phase.
  - Both clear on every phase entry.
  - Consequently SHOW lasts exactly SHOW_TICKS*TICK_DIV cycles and RESULT lasts exactly RES_TICKS*TICK_DIV cycles.
- SHOW:
  - disp_value={a,b}.
  - On the final tick: unsigned a>b goes to RESULT_SUB; otherwise (including a==b) goes to RESULT_GRAY.
- RESULT_SUB: disp_value={4'b0, a-b}, range 1..15, never wraps.
- RESULT_GRAY: disp_value={a,b} ^ ({a,b}>>1), MSB preserved.
- End of a RESULT phase: on the final tick, go to IDLE. Simultaneously ack[grant_id]=1 for exactly one cycle and disp_value=8'hFF.
- Latency: with req sampled high in IDLE at edge k, phase=01 and disp_value={a,b} from edge k+1. The ack edge is at k+1+(SHOW_TICKS+RES_TICKS)*TICK_DIV.
- Requests dropped mid-transaction: the transaction still completes and still acks.
- A requester not served keeps req high and is served next.

Test Plan:
- Reset held 3 cycles, then released with no req -> phase=00, busy=0, disp_value=8'hFF, ack0=ack1=0 continuously.
- Defaults, req0 with a0=9, b0=3 -> 24 cycles phase=01 disp=0x93, then 12 cycles phase=10 disp=0x06, then ack0=1 for 1 cycle with phase=00 and disp=0xFF.
- req1 with a1=3, b1=9 -> 24 cycles disp=0x39, then 12 cycles phase=11 disp=0x25, then ack1 pulse, grant_id=1.
- req0 with a=b=5, operands changed to 0 mid-SHOW -> disp=0x55 throughout SHOW, then phase=11 disp=0x7F, then ack0.
- req0 and req1 both held high continuously -> grants alternate 0,1,0,1; each transaction is 37 cycles; 2 IDLE cycles between transactions; exactly one ack per transaction.
- reset asserted in SHOW cycle 10 of a req1 transaction -> next cycle phase=00, disp=0xFF, no ack1. With both reqs then high, requester 0 is granted first.

Source files
------------

// File: rtl/ab_display_scheduler.sv
// Round-robin scheduler sharing one operand display/compute path between two requesters.
// Each grant shows {a,b}, then a-b or the Gray code of {a,b}, then acks the owner.
module ab_display_scheduler #(
   parameter int TICK_DIV   = 4,
   parameter int SHOW_TICKS = 6,
   parameter int RES_TICKS  = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic       req1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       ack0,
   output logic       ack1,
   output logic       busy,
   output logic       grant_id,
   output logic [1:0] phase,
   output logic [7:0] disp_value
);

   localparam logic [1:0] PH_IDLE = 2'b00;
   localparam logic [1:0] PH_SHOW = 2'b01;
   localparam logic [1:0] PH_SUB  = 2'b10;
   localparam logic [1:0] PH_GRAY = 2'b11;
   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MAXT = (SHOW_TICKS > RES_TICKS) ? SHOW_TICKS : RES_TICKS;
   localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

   function automatic logic [7:0] gray8(input logic [7:0] v);
      return v ^ (v >> 1);
   endfunction

   logic [1:0]    phase_q, phase_d;
   logic [3:0]    a_q, a_d, b_q, b_d;
   logic          grant_q, grant_d;
   logic          last_q, last_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic          busy_q, busy_d;
   logic [7:0]    disp_q, disp_d;
   logic          tick_s, last_tick_s, sel_s;
   logic [TW-1:0] limit_s;

   // State register: every output and internal state is registered here
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= PH_IDLE;
         a_q     <= 4'h0;
         b_q     <= 4'h0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         pre_q   <= '0;
         cnt_q   <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         disp_q  <= 8'hFF;
      end else begin
         phase_q <= phase_d;
         a_q     <= a_d;
         b_q     <= b_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         disp_q  <= disp_d;
      end
   end

   // Next-state: arbitration, operand latch, phase sequencing and dwell timer
   always_comb begin
      phase_d = phase_q;
      a_d     = a_q;
      b_d     = b_q;
      grant_d = grant_q;
      last_d  = last_q;
      sel_s   = 1'b0;
      tick_s  = (pre_q == PW'(TICK_DIV - 1));
      if (phase_q == PH_SHOW) begin
         limit_s = TW'(SHOW_TICKS - 1);
      end else begin
         limit_s = TW'(RES_TICKS - 1);
      end
      last_tick_s = tick_s && (cnt_q == limit_s);

      case (phase_q)
         PH_IDLE: begin
            // the ack cycle itself never grants, which enforces the 2-cycle gap
            if ((req0 || req1) && !ack0_q && !ack1_q) begin
               sel_s   = (req0 && req1) ? ~last_q : req1;
               grant_d = sel_s;
               last_d  = sel_s;
               a_d     = sel_s ? a1 : a0;
               b_d     = sel_s ? b1 : b0;
               phase_d = PH_SHOW;
            end else begin
               phase_d = PH_IDLE;
            end
         end
         PH_SHOW: begin
            if (last_tick_s) begin
               phase_d = (a_q > b_q) ? PH_SUB : PH_GRAY;
            end else begin
               phase_d = PH_SHOW;
            end
         end
         PH_SUB, PH_GRAY: begin
            if (last_tick_s) begin
               phase_d = PH_IDLE;
            end else begin
               phase_d = phase_q;
            end
         end
         default: phase_d = PH_IDLE;
      endcase

      if ((phase_d != phase_q) || (phase_q == PH_IDLE)) begin
         pre_d = '0;
         cnt_d = '0;
      end else if (tick_s) begin
         pre_d = '0;
         cnt_d = cnt_q + TW'(1);
      end else begin
         pre_d = pre_q + PW'(1);
         cnt_d = cnt_q;
      end
   end

   // Output decode from the next state so the registered outputs line up with phase
   always_comb begin
      ack0_d = 1'b0;
      ack1_d = 1'b0;
      if (phase_q[1] && (phase_d == PH_IDLE)) begin
         ack0_d = ~grant_q;
         ack1_d = grant_q;
      end else begin
         ack0_d = 1'b0;
         ack1_d = 1'b0;
      end
      busy_d = (phase_d != PH_IDLE);
      case (phase_d)
         PH_IDLE: disp_d = 8'hFF;
         PH_SHOW: disp_d = {a_d, b_d};
         PH_SUB:  disp_d = {4'h0, a_d - b_d};
         PH_GRAY: disp_d = gray8({a_d, b_d});
         default: disp_d = 8'hFF;
      endcase
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign busy       = busy_q;
   assign grant_id   = grant_q;
   assign phase      = phase_q;
   assign disp_value = disp_q;

endmodule

// File: tb/tb_ab_display_scheduler.sv
// Directed table-driven bench for ab_display_scheduler, plus hand-written
// sequences for round robin and reset in the middle of a transaction.
module tb_ab_display_scheduler;

   localparam int SHOW_CYC = 24;
   localparam int RES_CYC  = 12;

   logic       clock = 1'b0;
   logic       reset;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic       ack0, ack1, busy, grant_id;
   logic [1:0] phase;
   logic [7:0] disp_value;

   int n_pass = 0;
   int n_total = 0;

   ab_display_scheduler #(.TICK_DIV(4), .SHOW_TICKS(6), .RES_TICKS(3)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .busy(busy), .grant_id(grant_id),
      .phase(phase), .disp_value(disp_value)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       r0;
      logic [3:0] a0;
      logic [3:0] b0;
      logic       r1;
      logic [3:0] a1;
      logic [3:0] b1;
      logic       gid;
      logic [7:0] show;
      logic [1:0] rph;
      logic [7:0] rdisp;
      bit         chg;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Follows one transaction from its grant edge through the idle cycle after the ack.
   task automatic run_txn(input logic gid, input logic [7:0] show, input logic [1:0] rph,
                          input logic [7:0] rdisp, input bit drop, input bit chg);
      int waitc = 0;
      int bad;
      do begin
         @(negedge clock);
         waitc++;
      end while (phase !== 2'b01 && waitc < 60);
      chk("grant_latency", waitc, 1);
      chk("grant_id", grant_id, gid);
      if (drop) begin
         if (gid) req1 = 1'b0;
         else     req0 = 1'b0;
      end
      bad = 0;
      for (int i = 0; i < SHOW_CYC; i++) begin
         if (phase !== 2'b01 || disp_value !== show || ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b1)
            bad++;
         if (chg && i == 10) begin
            a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
         end
         @(negedge clock);
      end
      chk("show_bad_cycles", bad, 0);
      bad = 0;
      for (int i = 0; i < RES_CYC; i++) begin
         if (phase !== rph || disp_value !== rdisp || ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b1)
            bad++;
         @(negedge clock);
      end
      chk("result_bad_cycles", bad, 0);
      chk("ack_cycle {phase,busy,ack1,ack0,disp}", {phase, busy, ack1, ack0, disp_value},
          {2'b00, 1'b0, gid, ~gid, 8'hFF});
      @(negedge clock);
      chk("post_ack_idle {phase,ack1,ack0,disp}", {phase, ack1, ack0, disp_value},
          {2'b00, 1'b0, 1'b0, 8'hFF});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      vecs[0] = '{1'b1, 4'h9, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 8'h93, 2'b10, 8'h06, 1'b0};
      vecs[1] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h9, 1'b1, 8'h39, 2'b11, 8'h25, 1'b0};
      vecs[2] = '{1'b1, 4'h5, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 8'h55, 2'b11, 8'h7F, 1'b1};
      vecs[3] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 1'b1, 8'hF0, 2'b10, 8'h0F, 1'b0};
      vecs[4] = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 8'h0F, 2'b11, 8'h08, 1'b0};
      vecs[5] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h3, 1'b1, 8'h43, 2'b10, 8'h01, 1'b0};

      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
      repeat (3) @(negedge clock);
      chk("in_reset {phase,busy,ack1,ack0,gid,disp}", {phase, busy, ack1, ack0, grant_id, disp_value},
          {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF});
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (phase !== 2'b00 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || disp_value !== 8'hFF)
            bad++;
      end
      chk("idle_after_reset_bad_cycles", bad, 0);

      foreach (vecs[i]) begin
         req0 = vecs[i].r0; a0 = vecs[i].a0; b0 = vecs[i].b0;
         req1 = vecs[i].r1; a1 = vecs[i].a1; b1 = vecs[i].b1;
         run_txn(vecs[i].gid, vecs[i].show, vecs[i].rph, vecs[i].rdisp, 1'b1, vecs[i].chg);
      end

      // both requesters held high: last served was 1, so grants go 0,1,0,1
      req0 = 1'b1; a0 = 4'h1; b0 = 4'h2;
      req1 = 1'b1; a1 = 4'h2; b1 = 4'h1;
      for (int t = 0; t < 4; t++) begin
         if (t % 2 == 0) run_txn(1'b0, 8'h12, 2'b11, 8'h1B, 1'b0, 1'b0);
         else            run_txn(1'b1, 8'h21, 2'b10, 8'h01, 1'b0, 1'b0);
      end

      // reset in SHOW cycle 10 of a req1 transaction
      req0 = 1'b0;
      a1 = 4'h7; b1 = 4'h1;
      @(negedge clock);
      chk("rst1_grant {phase,gid,disp}", {phase, grant_id, disp_value}, {2'b01, 1'b1, 8'h71});
      repeat (10) @(negedge clock);
      reset = 1'b1;
      req0 = 1'b1; a0 = 4'h4; b0 = 4'h2;
      @(negedge clock);
      chk("rst1_abort {phase,busy,ack1,ack0,gid,disp}", {phase, busy, ack1, ack0, grant_id, disp_value},
          {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF});
      reset = 1'b0;
      @(negedge clock);
      chk("rst1_regrant {phase,gid,ack1,disp}", {phase, grant_id, ack1, disp_value},
          {2'b01, 1'b0, 1'b0, 8'h42});

      // reset during a req0 transaction: requester 0 must still win next contention
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst2_abort {phase,ack0,disp}", {phase, ack0, disp_value}, {2'b00, 1'b0, 8'hFF});
      reset = 1'b0;
      @(negedge clock);
      chk("rst2_regrant {phase,gid,disp}", {phase, grant_id, disp_value}, {2'b01, 1'b0, 8'h42});
      req0 = 1'b0; req1 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
